// File: rtl/multicycle_controller.sv
// Main control FSM for the multicycle RV32I datapath.
// Latency: Moore outputs per state; branch 3, R/I/sw/lui/jal 4, lw/jalr 5 cycles.
// No backpressure: advances every cycle; ILLEGAL holds (or refetches) per HALT_ON_ILLEGAL.
module multicycle_controller #(
  parameter logic HALT_ON_ILLEGAL = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic       f7b5,
  input  logic       zero,
  input  logic       lt,
  input  logic       bge,
  output logic       PCWrite,
  output logic       AdrSrc,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       RegWrite,
  output logic [1:0] ResultSrc,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [2:0] ALUControl,
  output logic [2:0] ImmSrc,
  output logic       illegal
);

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;

  localparam logic [2:0] ALU_ADD  = 3'd0;
  localparam logic [2:0] ALU_SUB  = 3'd1;
  localparam logic [2:0] ALU_AND  = 3'd2;
  localparam logic [2:0] ALU_OR   = 3'd3;
  localparam logic [2:0] ALU_SLT  = 3'd4;
  localparam logic [2:0] ALU_XOR  = 3'd5;
  localparam logic [2:0] ALU_SLTU = 3'd6;

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB, S_MEMWRITE,
    S_EXECR, S_EXECI, S_ALUWB, S_BRANCH, S_JAL, S_JALR1, S_JALR2,
    S_LUI, S_ILLEGAL
  } state_t;

  state_t     state_q, state_d;
  logic [2:0] funct_alu;
  logic       shift_f3;

  // Shift encodings are not supported by this ALU and are trapped as illegal.
  assign shift_f3 = (funct3 == 3'b001) || (funct3 == 3'b101);

  // State register; async reset lands directly in FETCH so no write strobe survives.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_FETCH;
    else        state_q <= state_d;
  end

  // ALU operation for R/I execute; SUB only for R-type (op[5]) with f7b5.
  always_comb begin
    funct_alu = ALU_ADD;
    case (funct3)
      3'b000:  funct_alu = (op[5] && f7b5) ? ALU_SUB : ALU_ADD;
      3'b010:  funct_alu = ALU_SLT;
      3'b011:  funct_alu = ALU_SLTU;
      3'b100:  funct_alu = ALU_XOR;
      3'b110:  funct_alu = ALU_OR;
      3'b111:  funct_alu = ALU_AND;
      default: funct_alu = ALU_ADD;
    endcase
  end

  // Immediate format follows the opcode directly, independent of state.
  always_comb begin
    ImmSrc = 3'b000;
    case (op)
      OP_STORE:  ImmSrc = 3'b001;
      OP_BRANCH: ImmSrc = 3'b010;
      OP_JAL:    ImmSrc = 3'b011;
      OP_LUI:    ImmSrc = 3'b100;
      default:   ImmSrc = 3'b000;
    endcase
  end

  // Next-state and Moore output decode; everything defaults to 0.
  always_comb begin
    state_d    = state_q;
    PCWrite    = 1'b0;
    AdrSrc     = 1'b0;
    MemWrite   = 1'b0;
    IRWrite    = 1'b0;
    RegWrite   = 1'b0;
    ResultSrc  = 2'b00;
    ALUSrcA    = 2'b00;
    ALUSrcB    = 2'b00;
    ALUControl = ALU_ADD;
    illegal    = 1'b0;
    case (state_q)
      S_FETCH: begin
        IRWrite   = 1'b1;
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
        PCWrite   = 1'b1;
        state_d   = S_DECODE;
      end
      S_DECODE: begin
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b01;
        case (op)
          OP_LOAD, OP_STORE: state_d = S_MEMADR;
          OP_R:      state_d = shift_f3 ? S_ILLEGAL : S_EXECR;
          OP_I:      state_d = shift_f3 ? S_ILLEGAL : S_EXECI;
          // Valid branch funct3 values (beq/bne/blt/bge) all have bit 1 clear.
          OP_BRANCH: state_d = funct3[1] ? S_ILLEGAL : S_BRANCH;
          OP_JAL:    state_d = S_JAL;
          OP_JALR:   state_d = S_JALR1;
          OP_LUI:    state_d = S_LUI;
          default:   state_d = S_ILLEGAL;
        endcase
      end
      S_MEMADR: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
        state_d = op[5] ? S_MEMWRITE : S_MEMREAD;
      end
      S_MEMREAD: begin
        AdrSrc  = 1'b1;
        state_d = S_MEMWB;
      end
      S_MEMWB: begin
        ResultSrc = 2'b01;
        RegWrite  = 1'b1;
        state_d   = S_FETCH;
      end
      S_MEMWRITE: begin
        AdrSrc   = 1'b1;
        MemWrite = 1'b1;
        state_d  = S_FETCH;
      end
      S_EXECR: begin
        ALUSrcA    = 2'b10;
        ALUControl = funct_alu;
        state_d    = S_ALUWB;
      end
      S_EXECI: begin
        ALUSrcA    = 2'b10;
        ALUSrcB    = 2'b01;
        ALUControl = funct_alu;
        state_d    = S_ALUWB;
      end
      S_ALUWB: begin
        RegWrite = 1'b1;
        state_d  = S_FETCH;
      end
      S_BRANCH: begin
        ALUSrcA    = 2'b10;
        ALUControl = ALU_SUB;
        PCWrite    = ((funct3 == 3'b000) &&  zero) ||
                     ((funct3 == 3'b001) && !zero) ||
                     ((funct3 == 3'b100) &&  lt)   ||
                     ((funct3 == 3'b101) &&  bge);
        state_d    = S_FETCH;
      end
      S_JAL: begin
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b10;
        PCWrite = 1'b1;
        state_d = S_ALUWB;
      end
      S_JALR1: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
        state_d = S_JALR2;
      end
      S_JALR2: begin
        PCWrite = 1'b1;
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b10;
        state_d = S_ALUWB;
      end
      S_LUI: begin
        ALUSrcA = 2'b11;
        ALUSrcB = 2'b01;
        state_d = S_ALUWB;
      end
      S_ILLEGAL: begin
        illegal = 1'b1;
        state_d = HALT_ON_ILLEGAL ? S_ILLEGAL : S_FETCH;
      end
      default: state_d = S_FETCH;
    endcase
  end

endmodule

// File: tb/tb_multicycle_controller.sv
// Testbench for multicycle_controller: random instructions, scoreboard of per-cycle outputs.
// Driver pushes the expected output vector of every cycle; monitor pops/compares each negedge.
// Resets (initial, mid-instruction, after ILLEGAL) are part of the expected stream.
module tb_multicycle_controller;

  typedef struct packed {
    logic       pcw, adr, mw, irw, rw;
    logic [1:0] rs, sa, sb;
    logic [2:0] alu, imm;
    logic       ill;
  } ov_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [6:0] op = 7'd0;
  logic [2:0] funct3 = 3'd0;
  logic       f7b5 = 1'b0, zero = 1'b0, lt = 1'b0, bge = 1'b0;
  logic       PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, illegal;
  logic [1:0] ResultSrc, ALUSrcA, ALUSrcB;
  logic [2:0] ALUControl, ImmSrc;

  int  vectors = 0;
  int  miscompares = 0;
  ov_t exp_q[$];

  multicycle_controller #(.HALT_ON_ILLEGAL(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .op(op), .funct3(funct3), .f7b5(f7b5),
    .zero(zero), .lt(lt), .bge(bge),
    .PCWrite(PCWrite), .AdrSrc(AdrSrc), .MemWrite(MemWrite), .IRWrite(IRWrite),
    .RegWrite(RegWrite), .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
    .ALUControl(ALUControl), .ImmSrc(ImmSrc), .illegal(illegal)
  );

  always #5 clk = ~clk;

  function automatic ov_t mk(input logic pcw, adr, mw, irw, rw,
                             input logic [1:0] rs, sa, sb,
                             input logic [2:0] alu, input logic ill);
    ov_t r;
    r = '{pcw: pcw, adr: adr, mw: mw, irw: irw, rw: rw, rs: rs, sa: sa, sb: sb,
          alu: alu, imm: 3'd0, ill: ill};
    return r;
  endfunction

  function automatic logic [2:0] imm_of(input logic [6:0] o);
    case (o)
      7'b0100011: return 3'd1;
      7'b1100011: return 3'd2;
      7'b1101111: return 3'd3;
      7'b0110111: return 3'd4;
      default:    return 3'd0;
    endcase
  endfunction

  // Arithmetic op number for R/I instructions (ADD0 SUB1 AND2 OR3 SLT4 XOR5 SLTU6).
  function automatic logic [2:0] alu_of(input logic is_r, input logic [2:0] f, input logic b5);
    case (f)
      3'd0:    return (is_r && b5) ? 3'd1 : 3'd0;
      3'd2:    return 3'd4;
      3'd3:    return 3'd6;
      3'd4:    return 3'd5;
      3'd6:    return 3'd3;
      3'd7:    return 3'd2;
      default: return 3'd0;
    endcase
  endfunction

  // Monitor: every cycle with an outstanding expectation is compared.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      ov_t e, a;
      e = exp_q.pop_front();
      a = '{pcw: PCWrite, adr: AdrSrc, mw: MemWrite, irw: IRWrite, rw: RegWrite,
            rs: ResultSrc, sa: ALUSrcA, sb: ALUSrcB, alu: ALUControl, imm: ImmSrc,
            ill: illegal};
      vectors++;
      if (a !== e) begin
        miscompares++;
        $display("FAIL outvec t=%0t op=%b f3=%b got pcw%b adr%b mw%b irw%b rw%b rs%b sa%b sb%b alu%0d imm%0d ill%b exp pcw%b adr%b mw%b irw%b rw%b rs%b sa%b sb%b alu%0d imm%0d ill%b",
                 $time, op, funct3, a.pcw, a.adr, a.mw, a.irw, a.rw, a.rs, a.sa, a.sb,
                 a.alu, a.imm, a.ill, e.pcw, e.adr, e.mw, e.irw, e.rw, e.rs, e.sa,
                 e.sb, e.alu, e.imm, e.ill);
      end
    end
  end

  // Called just after a posedge: holds reset for n cycles; each of them must show FETCH decode.
  task automatic do_reset(input int n);
    ov_t f;
    f = mk(1, 0, 0, 1, 0, 2'b10, 2'b00, 2'b10, 3'd0, 0);
    f.imm = imm_of(op);
    rst_n = 1'b0;
    for (int i = 0; i < n; i++) exp_q.push_back(f);
    repeat (n) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  // Called just after a posedge with the DUT in FETCH. cut>0 asserts reset after cut cycles.
  task automatic run_instr(input logic [6:0] o, input logic [2:0] f, input logic b5,
                           input logic z, input logic l, input logic g, input int cut);
    ov_t seq[$];
    ov_t wb;
    logic bad, tk;
    int n;
    op = o; funct3 = f; f7b5 = b5; zero = z; lt = l; bge = g;
    wb = mk(0, 0, 0, 0, 1, 2'b00, 2'b00, 2'b00, 3'd0, 0);
    bad = 1'b0;
    seq.push_back(mk(1, 0, 0, 1, 0, 2'b10, 2'b00, 2'b10, 3'd0, 0));
    seq.push_back(mk(0, 0, 0, 0, 0, 2'b00, 2'b01, 2'b01, 3'd0, 0));
    case (o)
      7'b0000011: begin
        seq.push_back(mk(0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 3'd0, 0));
        seq.push_back(mk(0, 1, 0, 0, 0, 2'b00, 2'b00, 2'b00, 3'd0, 0));
        seq.push_back(mk(0, 0, 0, 0, 1, 2'b01, 2'b00, 2'b00, 3'd0, 0));
      end
      7'b0100011: begin
        seq.push_back(mk(0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 3'd0, 0));
        seq.push_back(mk(0, 1, 1, 0, 0, 2'b00, 2'b00, 2'b00, 3'd0, 0));
      end
      7'b0110011, 7'b0010011: begin
        if (f == 3'd1 || f == 3'd5) bad = 1'b1;
        else begin
          seq.push_back(mk(0, 0, 0, 0, 0, 2'b00, 2'b10, (o[5] ? 2'b00 : 2'b01),
                           alu_of(o == 7'b0110011, f, b5), 0));
          seq.push_back(wb);
        end
      end
      7'b1100011: begin
        case (f)
          3'd0:    tk = z;
          3'd1:    tk = !z;
          3'd4:    tk = l;
          3'd5:    tk = g;
          default: tk = 1'b0;
        endcase
        if (f == 3'd0 || f == 3'd1 || f == 3'd4 || f == 3'd5)
          seq.push_back(mk(tk, 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 3'd1, 0));
        else bad = 1'b1;
      end
      7'b1101111: begin
        seq.push_back(mk(1, 0, 0, 0, 0, 2'b00, 2'b01, 2'b10, 3'd0, 0));
        seq.push_back(wb);
      end
      7'b1100111: begin
        seq.push_back(mk(0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 3'd0, 0));
        seq.push_back(mk(1, 0, 0, 0, 0, 2'b00, 2'b01, 2'b10, 3'd0, 0));
        seq.push_back(wb);
      end
      7'b0110111: begin
        seq.push_back(mk(0, 0, 0, 0, 0, 2'b00, 2'b11, 2'b01, 3'd0, 0));
        seq.push_back(wb);
      end
      default: bad = 1'b1;
    endcase
    if (bad)
      for (int i = 0; i < 10; i++)
        seq.push_back(mk(0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 3'd0, 1));
    n = (cut > 0 && cut < seq.size()) ? cut : seq.size();
    for (int i = 0; i < n; i++) begin
      ov_t r;
      r = seq[i];
      r.imm = imm_of(o);
      exp_q.push_back(r);
    end
    repeat (n) @(posedge clk);
    #1;
    if (bad || n < seq.size()) do_reset(2);
  endtask

  logic [6:0] ops [10] = '{7'b0000011, 7'b0100011, 7'b0110011, 7'b0010011, 7'b1100011,
                           7'b1101111, 7'b1100111, 7'b0110111, 7'b1111111, 7'b0000000};

  initial begin
    @(posedge clk);
    #1 do_reset(2);
    // Directed cases from the block's test plan.
    run_instr(7'b0110011, 3'd0, 1'b0, 0, 0, 1, 0);  // add
    run_instr(7'b0110011, 3'd0, 1'b1, 0, 0, 1, 0);  // sub
    run_instr(7'b0010011, 3'd0, 1'b1, 0, 0, 1, 0);  // addi with f7b5 set
    run_instr(7'b0000011, 3'd2, 1'b0, 0, 0, 1, 0);  // lw
    run_instr(7'b0100011, 3'd2, 1'b0, 0, 0, 1, 0);  // sw
    run_instr(7'b1100011, 3'd0, 1'b0, 1, 0, 1, 0);  // beq taken
    run_instr(7'b1100011, 3'd1, 1'b0, 1, 0, 1, 0);  // bne not taken
    run_instr(7'b1100011, 3'd4, 1'b0, 0, 1, 0, 0);  // blt taken
    run_instr(7'b1100011, 3'd5, 1'b0, 0, 1, 0, 0);  // bge not taken
    run_instr(7'b1101111, 3'd0, 1'b0, 0, 0, 1, 0);  // jal
    run_instr(7'b1100111, 3'd0, 1'b0, 0, 0, 1, 0);  // jalr
    run_instr(7'b0110111, 3'd0, 1'b0, 0, 0, 1, 0);  // lui
    run_instr(7'b1111111, 3'd0, 1'b0, 0, 0, 1, 0);  // illegal, held 10 cycles
    run_instr(7'b0100011, 3'd2, 1'b0, 0, 0, 1, 3);  // reset lands in MEMWRITE
    run_instr(7'b0110011, 3'd1, 1'b0, 0, 0, 1, 0);  // shift -> illegal
    run_instr(7'b1100011, 3'd2, 1'b0, 0, 0, 1, 0);  // bad branch funct3
    // Random instruction stream with occasional mid-instruction resets.
    for (int k = 0; k < 400; k++) begin
      logic [6:0] o;
      logic z, l;
      int cut;
      o = ($urandom_range(0, 15) == 0) ? 7'($urandom) : ops[$urandom_range(0, 9)];
      z = 1'($urandom);
      l = z ? 1'b0 : 1'($urandom);
      cut = ($urandom_range(0, 15) == 0) ? $urandom_range(1, 5) : 0;
      run_instr(o, 3'($urandom), 1'($urandom), z, l, !l, cut);
    end
    @(negedge clk);
    #1;
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL drain leftover=%0d expected 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
